// File: rtl/bcd_count_scan_ctrl.sv
// bcd_count_scan_ctrl: run/hold/clear BCD counter with multiplexed seven-segment scan.
// Optional COUNT_DOWN_EN adds the up_down port for decrementing steps.
module bcd_count_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 12000,
  parameter int COUNT_DIV = 1200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_stop,
  input  logic              clear,
`ifdef COUNT_DOWN_EN
  input  logic              up_down,
`endif
  output logic [8:0]        seg_led,
  output logic [DIGITS-1:0] dig_sel,
  output logic              running,
  output logic              overflow
);
  localparam int CW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CMAX = CW'(COUNT_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE = DIGITS'(1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                  r_state, w_next;
  logic [CW-1:0]           r_cpre;
  logic [SW-1:0]           r_spre;
  logic [IW-1:0]           r_idx;
  logic [DIGITS-1:0][3:0]  r_dig, w_step;
  logic                    w_up, w_tick, w_carry;
  logic [3:0]              w_lim, w_wrap;

`ifdef COUNT_DOWN_EN
  assign w_up = up_down;
`else
  assign w_up = 1'b1;
`endif
  assign w_lim  = w_up ? 4'd9 : 4'd0;
  assign w_wrap = w_up ? 4'd0 : 4'd9;
  assign w_tick = r_state == RUN && r_cpre == CMAX && !clear;

  function automatic logic [8:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 9'h03f;
      4'd1: seg7 = 9'h006;
      4'd2: seg7 = 9'h05b;
      4'd3: seg7 = 9'h04f;
      4'd4: seg7 = 9'h066;
      4'd5: seg7 = 9'h06d;
      4'd6: seg7 = 9'h07d;
      4'd7: seg7 = 9'h007;
      4'd8: seg7 = 9'h07f;
      4'd9: seg7 = 9'h06f;
      default: seg7 = 9'h000;
    endcase
  endfunction

  always_comb w_next = clear ? IDLE : !start_stop ? r_state : r_state == RUN ? HOLD : RUN;

  // Ripple the carry/borrow through every digit in one cycle; final carry is the wrap.
  always_comb begin
    w_carry = 1'b1;
    w_step  = r_dig;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) w_step[i] = r_dig[i] == w_lim ? w_wrap : w_up ? r_dig[i] + 4'd1 : r_dig[i] - 4'd1;
      w_carry = w_carry && r_dig[i] == w_lim;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cpre   <= '0;
      r_spre   <= '0;
      r_idx    <= '0;
      r_dig    <= '0;
      seg_led  <= 9'h03f;
      dig_sel  <= ~ONE;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_state  <= w_next;
      running  <= w_next == RUN;
      r_cpre   <= clear || r_state == IDLE ? '0 : r_state == HOLD ? r_cpre : r_cpre == CMAX ? '0 : r_cpre + 1'b1;
      r_dig    <= clear ? '0 : w_tick ? w_step : r_dig;
      overflow <= w_tick && w_carry;
      r_spre   <= r_spre == SMAX ? '0 : r_spre + 1'b1;
      if (r_spre == SMAX) r_idx <= r_idx == IMAX ? '0 : r_idx + 1'b1;
      seg_led  <= seg7(r_dig[r_idx]);
      dig_sel  <= ~(ONE << r_idx);
    end
  end
endmodule

// File: tb/tb_bcd_count_scan_ctrl.sv
// tb_bcd_count_scan_ctrl: random and directed stimulus against an integer-count reference model.
module tb_bcd_count_scan_ctrl;
  localparam int D = 4, SD = 4, CD = 10, MOD = 10000;
  logic clk = 0, rst = 0, ss = 0, clr = 0, ss2 = 0, clr2 = 0;
`ifdef COUNT_DOWN_EN
  logic ud = 1;
`endif
  logic [8:0] seg, seg2;
  logic [3:0] dig;
  logic [1:0] dig2;
  logic run, ovf, run2, ovf2;
  int n_chk = 0, n_fail = 0;
  int cyc_n = 0, n_ovf2 = 0, ovf2_at = -10, base = 0;
  logic [8:0] seg2_at_ovf = '0, seg2_after = '0;
  int m_state, m_cnt, m_pre, m_spre, m_idx, m_run, m_ovf;
  logic [8:0] m_seg;
  logic [3:0] m_dig;
  logic [3:0] seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  bcd_count_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .COUNT_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start_stop(ss), .clear(clr),
`ifdef COUNT_DOWN_EN
    .up_down(ud),
`endif
    .seg_led(seg), .dig_sel(dig), .running(run), .overflow(ovf));

  bcd_count_scan_ctrl #(.DIGITS(2), .SCAN_DIV(2), .COUNT_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .start_stop(ss2), .clear(clr2),
`ifdef COUNT_DOWN_EN
    .up_down(1'b1),
`endif
    .seg_led(seg2), .dig_sel(dig2), .running(run2), .overflow(ovf2));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [8:0] seg_of(input int v);
    logic [6:0] tab [10];
    tab = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
    return {2'b00, tab[v]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_cnt = 0; m_pre = 0; m_spre = 0; m_idx = 0; m_run = 0; m_ovf = 0;
    m_seg = 9'h03f; m_dig = 4'b1110;
  endtask

  // Model state: 0 idle, 1 run, 2 hold; count kept as a plain decimal integer.
  task automatic m_tick(input bit s, input bit c, input bit u);
    int digit;
    digit = (m_cnt / (10 ** m_idx)) % 10;
    m_seg = seg_of(digit);
    m_dig = 4'hf ^ (4'd1 << m_idx);
    if (m_spre == SD - 1) begin m_spre = 0; m_idx = (m_idx + 1) % D; end
    else m_spre++;
    m_ovf = 0;
    if (c) begin
      m_state = 0; m_cnt = 0; m_pre = 0;
    end else begin
      if (m_state == 1) begin
        if (m_pre == CD - 1) begin
          m_pre = 0;
          if (u) begin m_ovf = int'(m_cnt == MOD - 1); m_cnt = (m_cnt + 1) % MOD; end
          else begin m_ovf = int'(m_cnt == 0); m_cnt = (m_cnt + MOD - 1) % MOD; end
        end else m_pre++;
      end
      if (s) m_state = m_state == 1 ? 2 : 1;
    end
    m_run = int'(m_state == 1);
  endtask

  task automatic cyc(input bit s, input bit c, input bit u);
    bit u_eff;
    ss = s; clr = c;
`ifdef COUNT_DOWN_EN
    ud = u; u_eff = u;
`else
    u_eff = 1'b1;
`endif
    @(posedge clk);
    m_tick(s, c, u_eff);
    @(negedge clk);
    ss = 0; clr = 0; ss2 = 0; clr2 = 0;
    cyc_n++;
    if (ovf2) begin n_ovf2++; ovf2_at = cyc_n; seg2_at_ovf = seg2; end
    if (cyc_n == ovf2_at + 1) seg2_after = seg2;
    chk("seg", 32'(seg), 32'(m_seg));
    chk("dig", 32'(dig), 32'(m_dig));
    chk("running", 32'(run), 32'(m_run));
    chk("overflow", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 1);
  endtask

  task automatic wait_dig0(input string tag);
    int k = 0;
    while (dig !== 4'b1110 && k < 8) begin cyc(0, 0, 1); k++; end
    chk({tag, "_scan"}, 32'(dig), 32'(4'b1110));
  endtask

  initial begin
    int k;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h03f);
    chk("rst_dig", 32'(dig), 32'(4'b1110));
    chk("rst_run", 32'(run), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1;
    k = 0;
    while (dig !== 4'b1101 && k < 10) begin cyc(0, 0, 1); k++; end
    for (int i = 0; i < 16; i++) begin
      chk("scan_seq", 32'(dig), 32'(seq[i / 4]));
      cyc(0, 0, 1);
    end
    cyc(1, 0, 1);
    chk("start_run", 32'(run), 1);
    idle(11);
    wait_dig0("step");
    chk("step_seg", 32'(seg), 32'h006);
    cyc(0, 1, 1);
    cyc(1, 0, 1);
    idle(4);
    cyc(1, 0, 1);
    idle(20);
    wait_dig0("hold");
    chk("hold_seg", 32'(seg), 32'h03f);
    chk("hold_run", 32'(run), 0);
    cyc(1, 0, 1);
    idle(5);
    idle(2);
    wait_dig0("resume");
    chk("resume_seg", 32'(seg), 32'h006);
    cyc(1, 1, 1);
    chk("clr_run", 32'(run), 0);
    idle(2);
    wait_dig0("clr");
    chk("clr_seg", 32'(seg), 32'h03f);
`ifdef COUNT_DOWN_EN
    cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 0);
    chk("down_ovf", 32'(ovf), 1);
    cyc(0, 0, 1);
    chk("down_ovf_len", 32'(ovf), 0);
    wait_dig0("down");
    chk("down_seg", 32'(seg), 32'h06f);
    cyc(0, 1, 1);
`endif
    clr2 = 1;
    cyc(0, 0, 1);
    ss2 = 1;
    cyc(0, 0, 1);
    base = cyc_n;
    n_ovf2 = 0;
    idle(210);
    chk("ovf2_count", 32'(n_ovf2), 1);
    chk("ovf2_cycle", 32'(ovf2_at - base), 200);
    chk("ovf2_seg_before", 32'(seg2_at_ovf), 32'h06f);
    chk("ovf2_seg_after", 32'(seg2_after), 32'h03f);
    chk("ovf2_run", 32'(run2), 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
    rst = 0;
    m_reset();
    #1;
    chk("arst_seg", 32'(seg), 32'h03f);
    chk("arst_dig", 32'(dig), 32'(4'b1110));
    chk("arst_run", 32'(run), 0);
    chk("arst_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 1) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
